rice_stream_writer2: RTL

//  Rice encoder and packer. It is the transmit counterpart of RiceStreamReader2.
//  - Takes signed residuals plus a per-symbol Rice parameter k.
//  - Folds each residual to unsigned: u = x>=0 ? 2x : -2x-1.
//  - Emits q=u>>k zeros, then a '1' stop bit, then the low k bits of u, MSB first.
//  - Output is 2 bits per clock. oData[1] is the earlier bit.
//  - Symbols are packed back to back with no gaps, so one pair may straddle two symbols.
//  - Sits between the residual/LPC stage and the frame bit-writer.

---
 rtl/rice_pkg.sv | 27 ++
 rtl/rice_fold.sv | 21 ++
 rtl/rice_stream_writer2.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/rice_pkg.sv
// ----------------------------------------------------------------------------
// rice_pkg
//   Shared definitions for the Rice stream writer:
//   - default residual / Rice parameter widths
//   - encoder FSM state encoding
//   - signed-to-unsigned fold (zig-zag) helper
// ----------------------------------------------------------------------------
package rice_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int PARAM_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_UNARY = 2'd1,
    ST_STOP  = 2'd2,
    ST_REM   = 2'd3
  } rice_state_e;

  // u = x>=0 ? 2x : -2x-1, written as (x<<1) ^ sign-mask. For negative x,
  // ~(2x) == -2x-1, so the most negative value maps to all-ones without
  // overflow. Works for any width up to 32 when the input is sign-extended.
  function automatic logic [31:0] rice_fold32(input logic signed [31:0] x);
    return {x[30:0], 1'b0} ^ {32{x[31]}};
  endfunction

endpackage

// File: rtl/rice_fold.sv
// ----------------------------------------------------------------------------
// rice_fold
//   Combinational signed-to-unsigned fold used when a residual is captured.
// Ports
//   x_i  in   DATA_W  signed residual (two's complement)
//   u_o  out  DATA_W  folded unsigned value
// ----------------------------------------------------------------------------
module rice_fold
  import rice_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic signed [DATA_W-1:0] x_i,
  output logic        [DATA_W-1:0] u_o
);

  // Sign-extend to the helper width, keep only the DATA_W low bits; the
  // zig-zag result always fits in DATA_W bits.
  assign u_o = DATA_W'(rice_fold32(32'(x_i)));

endmodule

// File: rtl/rice_stream_writer2.sv
// ----------------------------------------------------------------------------
// rice_stream_writer2
//   Rice encoder and 2-bit-per-clock packer. Each signed residual is folded to
//   unsigned u, then emitted as q=u>>k zeros, a '1' stop bit and the low k bits
//   of u (MSB first). Symbols are packed back to back; an odd trailing bit is
//   held until the next symbol or a flush.
// Ports
//   iClock      in   1        clock, rising edge
//   iReset_n    in   1        asynchronous active-low reset
//   iValid      in   1        iResidual / iRiceParam valid
//   iResidual   in   DATA_W   signed residual
//   iRiceParam  in   PARAM_W  Rice parameter k (k < DATA_W)
//   oReady      out  1        pending register empty; accept on iValid&&oReady
//   iFlush      in   1        pad a held odd bit with '0' and emit it
//   oData       out  2        bit pair, [1] is the earlier stream bit
//   oValid      out  1        oData valid
//   oIdle       out  1        nothing active, pending or held
// ----------------------------------------------------------------------------
module rice_stream_writer2
  import rice_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PARAM_W = PARAM_W_DEF
) (
  input  logic                      iClock,
  input  logic                      iReset_n,
  input  logic                      iValid,
  input  logic signed [DATA_W-1:0]  iResidual,
  input  logic        [PARAM_W-1:0] iRiceParam,
  output logic                      oReady,
  input  logic                      iFlush,
  output logic        [1:0]         oData,
  output logic                      oValid,
  output logic                      oIdle
);

  // Snapshot of the encoder as it walks through the bit slots of one cycle.
  typedef struct packed {
    rice_state_e        st;    // active symbol state
    logic [DATA_W-1:0]  qc;    // remaining unary zeros
    logic [PARAM_W-1:0] rc;    // remaining remainder bits
    logic [DATA_W-1:0]  sr;    // remainder bits, MSB-aligned
    logic               pv;    // pending symbol still waiting
    logic [1:0]         n;     // stream bits collected this cycle (0..2)
    logic [1:0]         bits;  // collected bits, [1] first
  } step_t;

  // Active symbol
  rice_state_e        state_q, state_d;
  logic [DATA_W-1:0]  q_cnt_q, q_cnt_d;
  logic [PARAM_W-1:0] rem_cnt_q, rem_cnt_d;
  logic [DATA_W-1:0]  rem_sr_q, rem_sr_d;
  // Pending (input holding) register
  logic               pend_valid_q, pend_valid_d;
  logic [DATA_W-1:0]  pend_u_q, pend_u_d;
  logic [PARAM_W-1:0] pend_k_q, pend_k_d;
  // Odd-bit hold
  logic               hold_valid_q, hold_valid_d;
  logic               hold_bit_q, hold_bit_d;
  // Registered outputs
  logic [1:0]         data_q, data_d;
  logic               valid_q, valid_d;

  logic [DATA_W-1:0]  fold_u;
  rice_state_e        ld_st;
  logic [DATA_W-1:0]  ld_qc;
  logic [DATA_W-1:0]  ld_sr;
  logic               accept;
  logic               flush_ok;
  step_t              s0, s1, s2;

  rice_fold #(.DATA_W(DATA_W)) u_fold (
    .x_i (iResidual),
    .u_o (fold_u)
  );

  // Values the pending symbol takes when it becomes active. The remainder
  // is left-aligned so its MSB is always sr[DATA_W-1]; k=0 shifts it all out.
  assign ld_qc = pend_u_q >> pend_k_q;
  assign ld_st = (ld_qc == '0) ? ST_STOP : ST_UNARY;
  assign ld_sr = pend_u_q << (DATA_W - int'(pend_k_q));

  assign accept   = iValid && !pend_valid_q;
  assign flush_ok = iFlush && (state_q == ST_IDLE) && !pend_valid_q;

  // One bit slot: load pending if nothing is active, then emit one bit.
  function automatic step_t slot_step(
    input step_t              s,
    input rice_state_e        l_st,
    input logic [DATA_W-1:0]  l_qc,
    input logic [PARAM_W-1:0] l_rc,
    input logic [DATA_W-1:0]  l_sr
  );
    step_t r;
    logic  b;
    r = s;
    b = 1'b0;
    if (r.n != 2'd2) begin
      if (r.st == ST_IDLE && r.pv) begin
        r.st = l_st;
        r.qc = l_qc;
        r.rc = l_rc;
        r.sr = l_sr;
        r.pv = 1'b0;
      end
      if (r.st != ST_IDLE) begin
        case (r.st)
          ST_UNARY: begin
            b = 1'b0;
            if (r.qc == DATA_W'(1)) r.st = ST_STOP;
            r.qc = r.qc - DATA_W'(1);
          end
          ST_STOP: begin
            b = 1'b1;
            r.st = (r.rc == '0) ? ST_IDLE : ST_REM;
          end
          ST_REM: begin
            b = r.sr[DATA_W-1];
            r.sr = {r.sr[DATA_W-2:0], 1'b0};
            if (r.rc == PARAM_W'(1)) r.st = ST_IDLE;
            r.rc = r.rc - PARAM_W'(1);
          end
          default: b = 1'b0;
        endcase
        if (r.n == 2'd0) r.bits[1] = b;
        else             r.bits[0] = b;
        r.n = r.n + 2'd1;
      end
    end
    return r;
  endfunction

  always_comb begin
    // A held bit always occupies the first slot of the pair.
    s0.st   = state_q;
    s0.qc   = q_cnt_q;
    s0.rc   = rem_cnt_q;
    s0.sr   = rem_sr_q;
    s0.pv   = pend_valid_q;
    s0.n    = hold_valid_q ? 2'd1 : 2'd0;
    s0.bits = {hold_bit_q, 1'b0};
    s1 = slot_step(s0, ld_st, ld_qc, pend_k_q, ld_sr);
    s2 = slot_step(s1, ld_st, ld_qc, pend_k_q, ld_sr);

    state_d      = s2.st;
    q_cnt_d      = s2.qc;
    rem_cnt_d    = s2.rc;
    rem_sr_d     = s2.sr;
    pend_valid_d = s2.pv;
    pend_u_d     = pend_u_q;
    pend_k_d     = pend_k_q;
    hold_valid_d = 1'b0;
    hold_bit_d   = hold_bit_q;
    data_d       = data_q;
    valid_d      = 1'b0;

    if (s2.n == 2'd2) begin
      valid_d = 1'b1;
      data_d  = s2.bits;
    end else if (s2.n == 2'd1) begin
      if (flush_ok) begin
        // Nothing in flight, so the single bit is the old hold bit.
        valid_d = 1'b1;
        data_d  = {s2.bits[1], 1'b0};
      end else begin
        hold_valid_d = 1'b1;
        hold_bit_d   = s2.bits[1];
      end
    end

    // Accept only when pending is empty at cycle start, so it never
    // collides with a load from pending in the same cycle.
    if (accept) begin
      pend_valid_d = 1'b1;
      pend_u_d     = fold_u;
      pend_k_d     = iRiceParam;
    end
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q      <= ST_IDLE;
      q_cnt_q      <= '0;
      rem_cnt_q    <= '0;
      rem_sr_q     <= '0;
      pend_valid_q <= 1'b0;
      pend_u_q     <= '0;
      pend_k_q     <= '0;
      hold_valid_q <= 1'b0;
      hold_bit_q   <= 1'b0;
      data_q       <= 2'b00;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      q_cnt_q      <= q_cnt_d;
      rem_cnt_q    <= rem_cnt_d;
      rem_sr_q     <= rem_sr_d;
      pend_valid_q <= pend_valid_d;
      pend_u_q     <= pend_u_d;
      pend_k_q     <= pend_k_d;
      hold_valid_q <= hold_valid_d;
      hold_bit_q   <= hold_bit_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
    end
  end

  assign oReady = !pend_valid_q;
  assign oData  = data_q;
  assign oValid = valid_q;
  assign oIdle  = (state_q == ST_IDLE) && !pend_valid_q && !hold_valid_q;

endmodule
